em_reg: RTL and testbench

EM_REG -- requirements
Module: em_reg

---
 rtl/em_reg_pkg.sv | 8 +
 rtl/em_reg_pipe_field.sv | 33 +++
 rtl/em_reg.sv | 58 +++++
 tb/tb_em_reg.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/em_reg_pkg.sv
// Constants shared by the pipeline registers (FD/DE/EM/MW): default data width
// and the value loaded on reset or bubble insertion (all-zero, i.e. a nop).
package em_reg_pkg;

  localparam int          PIPE_DW     = 32;
  localparam logic [31:0] PIPE_BUBBLE = 32'h0000_0000;

endpackage

// File: rtl/em_reg_pipe_field.sv
// pipe_field: one DW-wide pipeline register field with synchronous reset,
// synchronous clear (bubble) and load enable. Priority: reset > clr > en.
module pipe_field
  import em_reg_pkg::*;
#(
  parameter int DW = PIPE_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  logic [DW-1:0] q_r;

  // Field register: a held field never samples d, so X on d cannot leak in.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r <= DW'(PIPE_BUBBLE);
    end else if (clr) begin
      q_r <= DW'(PIPE_BUBBLE);
    end else if (en) begin
      q_r <= d;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/em_reg.sv
// em_reg: EX->MEM pipeline register (pc, instr, extImm, grf_rt, aluResult).
// Optional macro EM_REG_CLR_EN adds a synchronous bubble input clr.
module em_reg
  import em_reg_pkg::*;
#(
  parameter int DW = PIPE_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          halt,
`ifdef EM_REG_CLR_EN
  input  logic          clr,
`endif
  input  logic [DW-1:0] e_pc,
  input  logic [DW-1:0] e_instr,
  input  logic [DW-1:0] e_extImm,
  input  logic [DW-1:0] e_grf_rt,
  input  logic [DW-1:0] e_aluResult,
  output logic [DW-1:0] m_pc,
  output logic [DW-1:0] m_instr,
  output logic [DW-1:0] m_extImm,
  output logic [DW-1:0] m_grf_rt,
  output logic [DW-1:0] m_aluResult
);

  logic clr_s;
  logic en_s;

`ifdef EM_REG_CLR_EN
  assign clr_s = clr;
`else
  assign clr_s = 1'b0;
`endif

  // One shared enable keeps all five fields moving in lockstep.
  assign en_s = ~halt;

  pipe_field #(.DW(DW)) u_pc (
    .clk(clk), .reset(reset), .clr(clr_s), .en(en_s), .d(e_pc), .q(m_pc)
  );

  pipe_field #(.DW(DW)) u_instr (
    .clk(clk), .reset(reset), .clr(clr_s), .en(en_s), .d(e_instr), .q(m_instr)
  );

  pipe_field #(.DW(DW)) u_ext_imm (
    .clk(clk), .reset(reset), .clr(clr_s), .en(en_s), .d(e_extImm), .q(m_extImm)
  );

  pipe_field #(.DW(DW)) u_grf_rt (
    .clk(clk), .reset(reset), .clr(clr_s), .en(en_s), .d(e_grf_rt), .q(m_grf_rt)
  );

  pipe_field #(.DW(DW)) u_alu_result (
    .clk(clk), .reset(reset), .clr(clr_s), .en(en_s), .d(e_aluResult), .q(m_aluResult)
  );

endmodule

// File: tb/tb_em_reg.sv
// Self-checking bench for em_reg: a reference model computes the expected
// MEM-stage record per edge, pushes it to a queue, and each test pops/compares.
module tb_em_reg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] ext;
    logic [31:0] rt;
    logic [31:0] alu;
  } rec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        halt = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] e_pc = 32'h0;
  logic [31:0] e_instr = 32'h0;
  logic [31:0] e_extImm = 32'h0;
  logic [31:0] e_grf_rt = 32'h0;
  logic [31:0] e_aluResult = 32'h0;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_extImm;
  logic [31:0] m_grf_rt;
  logic [31:0] m_aluResult;

  rec_t model_v = '0;
  rec_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  em_reg #(.DW(32)) dut (
    .clk(clk),
    .reset(reset),
    .halt(halt),
`ifdef EM_REG_CLR_EN
    .clr(clr),
`endif
    .e_pc(e_pc),
    .e_instr(e_instr),
    .e_extImm(e_extImm),
    .e_grf_rt(e_grf_rt),
    .e_aluResult(e_aluResult),
    .m_pc(m_pc),
    .m_instr(m_instr),
    .m_extImm(m_extImm),
    .m_grf_rt(m_grf_rt),
    .m_aluResult(m_aluResult)
  );

  always #5 clk = ~clk;

  function automatic rec_t obs();
    return {m_pc, m_instr, m_extImm, m_grf_rt, m_aluResult};
  endfunction

  function automatic rec_t mk(input logic [31:0] pc, input logic [31:0] instr,
                              input logic [31:0] ext, input logic [31:0] rt,
                              input logic [31:0] alu);
    rec_t r;
    r.pc = pc; r.instr = instr; r.ext = ext; r.rt = rt; r.alu = alu;
    return r;
  endfunction

  // Drive one cycle at negedge, update model, push expectation, settle past posedge.
  task automatic drive_cycle(input logic rst, input logic hl, input logic cl, input rec_t e);
    @(negedge clk);
    reset = rst;
    halt  = hl;
    clr   = cl;
    {e_pc, e_instr, e_extImm, e_grf_rt, e_aluResult} = e;
    if (rst) begin
      model_v = '0;
`ifdef EM_REG_CLR_EN
    end else if (cl) begin
      model_v = '0;
`endif
    end else if (!hl) begin
      model_v = e;
    end
    exp_q.push_back(model_v);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rec_t ex;
    drive_cycle(1'b1, 1'b0, 1'b0, {5{32'hFFFF_FFFF}});
    ex = exp_q.pop_front();
    n_cmp++;
    if (obs() !== ex || obs() !== rec_t'(0)) begin
      n_err++;
      $display("FAIL reset: got %h want %h", obs(), ex);
    end
  endtask

  task automatic test_load();
    rec_t stim[2];
    rec_t ex;
    stim[0] = mk(32'h0000_3000, 32'h3C01_1234, 32'h0000_1234, 32'h0000_0000, 32'h1234_0000);
    stim[1] = mk(32'h0000_3004, 32'h8C22_0008, 32'hFFFF_FFF8, 32'hDEAD_BEEF, 32'h8000_0001);
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b0, 1'b0, 1'b0, stim[i]);
      ex = exp_q.pop_front();
      n_cmp++;
      if (obs() !== ex || m_pc !== stim[i].pc) begin
        n_err++;
        $display("FAIL load[%0d]: got %h want %h", i, obs(), ex);
      end
    end
  endtask

  task automatic test_halt();
    rec_t ex;
    rec_t xs;
    xs = 'x;
    drive_cycle(1'b0, 1'b0, 1'b0, mk(32'h3004, 32'h1111_1111, 32'h2, 32'h3, 32'h4));
    ex = exp_q.pop_front();
    for (int i = 0; i < 3; i++) begin
      // Field values other than pc go X while held; none may reach the outputs.
      xs.pc = 32'h3008;
      drive_cycle(1'b0, 1'b1, 1'b0, (i == 1) ? xs : mk(32'h3008, 32'h5, 32'h6, 32'h7, 32'h8));
      ex = exp_q.pop_front();
      n_cmp++;
      if (obs() !== ex || m_pc !== 32'h0000_3004) begin
        n_err++;
        $display("FAIL halt_hold[%0d]: got %h want %h", i, obs(), ex);
      end
    end
    drive_cycle(1'b0, 1'b0, 1'b0, mk(32'h3008, 32'h5, 32'h6, 32'h7, 32'h8));
    ex = exp_q.pop_front();
    n_cmp++;
    if (obs() !== ex || m_pc !== 32'h0000_3008) begin
      n_err++;
      $display("FAIL halt_release: got %h want %h", obs(), ex);
    end
  endtask

  task automatic test_halt_reset();
    rec_t ex;
    rec_t stim[4];
    logic rst_t[4];
    logic hl_t[4];
    stim[0] = mk(32'hA, 32'hB, 32'hC, 32'hD, 32'hE);
    stim[1] = mk(32'h1, 32'h2, 32'h3, 32'h4, 32'h5);
    stim[2] = mk(32'h6, 32'h7, 32'h8, 32'h9, 32'hA);
    stim[3] = mk(32'h300C, 32'h0000_0020, 32'h0, 32'h55, 32'h66);
    rst_t[0] = 1'b0; hl_t[0] = 1'b0;
    rst_t[1] = 1'b1; hl_t[1] = 1'b1;
    rst_t[2] = 1'b0; hl_t[2] = 1'b1;
    rst_t[3] = 1'b0; hl_t[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(rst_t[i], hl_t[i], 1'b0, stim[i]);
      ex = exp_q.pop_front();
      n_cmp++;
      if (obs() !== ex) begin
        n_err++;
        $display("FAIL halt_reset[%0d]: got %h want %h", i, obs(), ex);
      end
    end
  endtask

`ifdef EM_REG_CLR_EN
  task automatic test_clr();
    rec_t ex;
    drive_cycle(1'b0, 1'b0, 1'b0, mk(32'h3010, 32'hAC22_0004, 32'h4, 32'h99, 32'h1004));
    ex = exp_q.pop_front();
    drive_cycle(1'b0, 1'b1, 1'b1, mk(32'h3014, 32'h1, 32'h2, 32'h3, 32'h4));
    ex = exp_q.pop_front();
    n_cmp++;
    if (obs() !== ex || m_instr !== 32'h0) begin
      n_err++;
      $display("FAIL clr_halt: got %h want %h", obs(), ex);
    end
  endtask
`endif

  task automatic test_random();
    rec_t ex;
    rec_t e;
    logic rst_v;
    logic hl_v;
    logic cl_v;
    for (int i = 0; i < 1000; i++) begin
      e = mk($urandom, $urandom, $urandom, $urandom, $urandom);
      rst_v = ($urandom_range(0, 63) == 0);
      hl_v  = $urandom_range(0, 1) == 1;
`ifdef EM_REG_CLR_EN
      cl_v  = ($urandom_range(0, 15) == 0);
`else
      cl_v  = 1'b0;
`endif
      drive_cycle(rst_v, hl_v, cl_v, e);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL random[%0d]: scoreboard empty", i);
      end else begin
        ex = exp_q.pop_front();
        n_cmp++;
        if (obs() !== ex) begin
          n_err++;
          $display("FAIL random[%0d]: got %h want %h", i, obs(), ex);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_halt();
    test_halt_reset();
`ifdef EM_REG_CLR_EN
    test_clr();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
